// File: rtl/dac_sched_if.sv
// Sample-source handshake and DAC pin bundle for dac_sched.
// Sources drive valid/data; the scheduler returns ready and the DAC outputs.
interface dac_sched_if #(
  parameter int DOUT_WIDTH = 8,
  parameter int N_SRC      = 4
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]            src_valid;
  logic [N_SRC*DOUT_WIDTH-1:0] src_data;
  logic [N_SRC-1:0]            src_ready;
  logic                        dac_clk;
  logic [DOUT_WIDTH-1:0]       dout;
  logic [IW-1:0]               grant_id;
  logic                        underrun;

  modport master (
    output src_valid, src_data,
    input  src_ready, dac_clk, dout, grant_id, underrun
  );

  modport slave (
    input  src_valid, src_data,
    output src_ready, dac_clk, dout, grant_id, underrun
  );
endinterface

// File: rtl/dac_sched.sv
// DAC sample scheduler: divided DAC clock, one launch slot per period,
// round-robin arbitration across the sample sources.
module dac_sched #(
  parameter int DOUT_WIDTH = 8,
  parameter int N_SRC      = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 busy,
  dac_sched_if.slave           src
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t state, state_nx;

  logic [DIV_WIDTH-1:0]  counter;
  logic [DIV_WIDTH-1:0]  div_l;
  logic [DIV_WIDTH-1:0]  div_c;
  logic [DIV_WIDTH-1:0]  half;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         rr_nx;
  logic [IW-1:0]         win;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         grant_id;
  logic [DOUT_WIDTH-1:0] dout;
  logic [DOUT_WIDTH-1:0] data_a [N_SRC];
  logic [N_SRC-1:0]      ready;
  logic                  found;
  logic                  last;
  logic                  grant;
  logic                  dac_clk;
  logic                  underrun;

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign data_a[g] = src.src_data[g*DOUT_WIDTH +: DOUT_WIDTH];
  end

  assign div_c = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;
  assign half  = div_l >> 1;
  assign last  = counter == div_l - DIV_WIDTH'(1);
  assign grant = last && state == RUN && found && !rst;
  assign rr_nx = (win == IW'(N_SRC - 1)) ? '0 : win + IW'(1);
  assign busy  = state != IDLE;

  // Scan downward so the candidate nearest rr_ptr is the last to overwrite.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % N_SRC);
      if (src.src_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (grant) ready[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (enable) state_nx = RUN;
      RUN:  if (!enable) state_nx = STOP;
      STOP: begin
        if (enable)    state_nx = RUN;
        else if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter  <= '0;
      div_l    <= DIV_WIDTH'(2);
      rr_ptr   <= '0;
      dac_clk  <= 1'b0;
      dout     <= '0;
      grant_id <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (state == IDLE) begin
        counter <= '0;
        dac_clk <= 1'b0;
        if (enable) div_l <= div_c;
      end else if (last) begin
        counter <= '0;
        dac_clk <= 1'b0;
        div_l   <= div_c;
        if (state == RUN) begin
          if (found) begin
            dout     <= data_a[win];
            grant_id <= win;
            rr_ptr   <= rr_nx;
          end else begin
            underrun <= 1'b1;
          end
        end
      end else begin
        counter <= counter + DIV_WIDTH'(1);
        if (counter == half - DIV_WIDTH'(1)) dac_clk <= 1'b1;
      end
    end
  end

  assign src.src_ready = ready;
  assign src.dac_clk   = dac_clk;
  assign src.dout      = dout;
  assign src.grant_id  = grant_id;
  assign src.underrun  = underrun;
endmodule

// File: tb/tb_dac_sched.sv
// Scoreboard bench for dac_sched: period-level reference model feeds
// expectation queues that a separate monitor drains.
module tb_dac_sched;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int VW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [VW-1:0] div;
  logic          busy;

  dac_sched_if #(.DOUT_WIDTH(DW), .N_SRC(NS)) sif ();

  dac_sched #(
    .DOUT_WIDTH(DW),
    .N_SRC(NS),
    .DIV_WIDTH(VW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .div(div),
    .busy(busy),
    .src(sif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NS-1:0] rdy;
    logic          dac;
    logic          bsy;
    logic          und;
    logic [DW-1:0] dout;
    logic [IW-1:0] gid;
  } snap_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } gnt_t;

  snap_t cyc_q[$];
  gnt_t  gnt_q[$];

  int vectors = 0;
  int errors  = 0;

  logic          c_rst = 1'b1;
  logic          c_en  = 1'b0;
  int            c_div = 8;
  int            mode  = 0;
  logic [NS-1:0] sv    = '0;
  logic [DW-1:0] sd [NS];
  logic [NS-1:0] seen  = '0;

  // reference model: st 0 idle / 1 run / 2 stop, ph = position in period
  int            st    = 0;
  int            ph    = 0;
  int            md    = 2;
  int            rr    = 0;
  logic [DW-1:0] mdout = '0;
  int            mgid  = 0;
  logic          mund  = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampdiv(int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic drive();
    rst    = c_rst;
    enable = c_en;
    div    = VW'(c_div);
    for (int i = 0; i < NS; i++) begin
      if (seen[i]) sv[i] = 1'b0;
      case (mode)
        0: if (!sv[i] && $urandom_range(0, 1) == 1) begin
             sv[i] = 1'b1;
             sd[i] = DW'($urandom);
           end
        1: if (!sv[i]) begin
             sv[i] = 1'b1;
             sd[i] = DW'(8'hA0 + i);
           end
        2: sv[i] = 1'b0;
        default: begin
          sv[i] = (i == 0);
          sd[i] = (i == 0) ? 8'h11 : 8'h00;
        end
      endcase
      sif.src_data[i*DW +: DW] = sd[i];
    end
    sif.src_valid = sv;
  endtask

  task automatic cycle(int n);
    repeat (n) begin
      @(negedge clk);
      drive();
      #4;
      seen = sif.src_ready;
    end
  endtask

  // model: evaluates the current cycle, then advances to the next one
  initial begin
    forever begin
      snap_t s;
      gnt_t  g;
      int    win;
      bit    launch;
      @(negedge clk);
      #2;
      s.dac  = (st != 0) && (ph >= md / 2);
      s.bsy  = (st != 0);
      s.und  = mund;
      s.dout = mdout;
      s.gid  = IW'(mgid);
      s.rdy  = '0;
      launch = (st == 1) && (ph == md - 1) && !rst;
      win    = -1;
      if (launch) begin
        for (int j = 0; j < NS; j++) begin
          if (win < 0 && sv[(rr + j) % NS]) win = (rr + j) % NS;
        end
      end
      if (launch && win >= 0) begin
        s.rdy[win] = 1'b1;
        g.id   = win;
        g.data = sd[win];
        gnt_q.push_back(g);
      end
      cyc_q.push_back(s);
      if (rst) begin
        st = 0; ph = 0; md = 2; rr = 0;
        mdout = '0; mgid = 0; mund = 1'b0;
      end else begin
        mund = launch && (win < 0);
        if (launch && win >= 0) begin
          mdout = sd[win];
          mgid  = win;
          rr    = (win + 1) % NS;
        end
        if (st == 0) begin
          if (enable) begin
            st = 1; ph = 0; md = clampdiv(int'(div));
          end
        end else if (ph == md - 1) begin
          ph = 0;
          md = clampdiv(int'(div));
          st = enable ? 1 : ((st == 1) ? 2 : 0);
        end else begin
          ph++;
          st = enable ? 1 : 2;
        end
      end
    end
  end

  // monitor: compares DUT against queued expectations
  initial begin
    bit            pend = 1'b0;
    logic [DW-1:0] pd   = '0;
    int            pid  = 0;
    forever begin
      snap_t s;
      gnt_t  g;
      @(negedge clk);
      #4;
      if (cyc_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL cyc_q: got empty expected entry at %0t", $time);
      end else begin
        s = cyc_q.pop_front();
        chk("src_ready", 32'(sif.src_ready), 32'(s.rdy));
        chk("dac_clk", 32'(sif.dac_clk), 32'(s.dac));
        chk("busy", 32'(busy), 32'(s.bsy));
        chk("underrun", 32'(sif.underrun), 32'(s.und));
        chk("dout", 32'(sif.dout), 32'(s.dout));
        chk("grant_id", 32'(sif.grant_id), 32'(s.gid));
      end
      if (pend) begin
        chk("grant_dout", 32'(sif.dout), 32'(pd));
        chk("grant_gid", 32'(sif.grant_id), 32'(pid));
        pend = 1'b0;
      end
      if (sif.src_ready != '0) begin
        if (gnt_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL grant: got ready %0h expected none at %0t",
                   sif.src_ready, $time);
        end else begin
          g = gnt_q.pop_front();
          chk("grant_onehot", 32'(sif.src_ready), 32'(1) << g.id);
          pend = 1'b1;
          pd   = g.data;
          pid  = g.id;
        end
      end
    end
  end

  task automatic wait_phase(int want, string name);
    int budget = 200;
    while (!(st == 1 && ph == want) && budget > 0) begin
      cycle(1);
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      errors++;
      $display("FAIL %s: got timeout expected phase %0d", name, want);
    end
  endtask

  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    div           = VW'(8);
    sif.src_valid = '0;
    sif.src_data  = '0;
    for (int i = 0; i < NS; i++) sd[i] = '0;

    c_rst = 1'b1;
    cycle(3);
    c_rst = 1'b0;
    cycle(2);

    mode = 3; c_en = 1'b1; c_div = 8;
    cycle(40);

    mode = 1;
    cycle(48);

    mode = 2;
    cycle(20);
    mode = 1;
    cycle(20);

    c_div = 5; cycle(30);
    c_div = 0; cycle(12);
    c_div = 1; cycle(12);
    c_div = 2; cycle(8);

    c_div = 8;
    cycle(10);
    wait_phase(2, "disable_align");
    c_en = 1'b0;
    cycle(16);

    c_en = 1'b1; cycle(16);
    c_en = 1'b0; cycle(3);
    c_en = 1'b1; cycle(20);

    mode = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 29) == 0) c_div = $urandom_range(0, 9);
      if ($urandom_range(0, 49) == 0) c_en = ~c_en;
      cycle(1);
    end
    c_en = 1'b1;
    cycle(20);

    mode = 1; c_div = 6;
    cycle(12);
    wait_phase(md - 1, "reset_align");
    c_rst = 1'b1;
    cycle(1);
    c_rst = 1'b0;
    cycle(30);

    cycle(2);
    @(negedge clk);
    #6;
    chk("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
